// File: rtl/alu_bist_sweep.sv
// ---------------------------------------------------------------------------
// alu_bist_sweep
//   Hardware equivalence sweep for two ALUs that share the control/in_data1/
//   in_data2 interface. Walks every (in_data1, in_data2, control) vector with
//   control innermost, compares the two results after a settle window, counts
//   mismatches (saturating) and captures the first failing vector.
//
//   State table:
//     S_IDLE  | waiting for start, results of the last run are kept
//     S_HOLD  | vector driven, waiting SETTLE cycles for the ALUs to settle
//     S_CHECK | compare edge, then advance to the next vector or finish
//     S_DONE  | sweep complete, done/pass valid until next start
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        start pulse (IDLE/DONE), abort of a running sweep
//   control, in_data1,
//   in_data2            registered vector driven to both ALUs
//   out_data_dut/_ref   results of the ALU under test / reference ALU
//   busy, done, pass    sweep status
//   error_count         saturating mismatch count
//   err_valid, err_*    first failing vector with expected/actual results
// ---------------------------------------------------------------------------
module alu_bist_sweep #(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 5,
    parameter int SETTLE  = 1,
    parameter int CNT_W   = 2*WIDTH+3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [2:0]         control,
    output logic [WIDTH-1:0]   in_data1,
    output logic [WIDTH-1:0]   in_data2,
    input  logic [2*WIDTH-1:0] out_data_dut,
    input  logic [2*WIDTH-1:0] out_data_ref,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   error_count,
    output logic               err_valid,
    output logic [2:0]         err_control,
    output logic [WIDTH-1:0]   err_in1,
    output logic [WIDTH-1:0]   err_in2,
    output logic [2*WIDTH-1:0] err_exp,
    output logic [2*WIDTH-1:0] err_act
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [2:0] LAST_OP = 3'(NUM_OPS-1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_CHECK, S_DONE} state_t;

    state_t             state_q;
    logic [SW-1:0]      settle_q;
    logic [2:0]         control_q;
    logic [WIDTH-1:0]   in1_q;
    logic [WIDTH-1:0]   in2_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic               err_valid_q;
    logic [2:0]         err_control_q;
    logic [WIDTH-1:0]   err_in1_q;
    logic [WIDTH-1:0]   err_in2_q;
    logic [2*WIDTH-1:0] err_exp_q;
    logic [2*WIDTH-1:0] err_act_q;

    logic [2:0]         control_d;
    logic [WIDTH-1:0]   in1_d;
    logic [WIDTH-1:0]   in2_d;
    logic               last_vec;
    logic               mismatch;

    // Next vector in sweep order: control innermost, then in_data2, then in_data1.
    always_comb begin
        control_d = control_q + 3'd1;
        in1_d     = in1_q;
        in2_d     = in2_q;
        if (control_q == LAST_OP) begin
            control_d = 3'd0;
            in2_d     = in2_q + 1'b1;
            if (&in2_q) begin
                in1_d = in1_q + 1'b1;
            end
        end
    end

    assign last_vec = (control_q == LAST_OP) && (&in1_q) && (&in2_q);
    assign mismatch = (out_data_dut != out_data_ref);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            settle_q      <= '0;
            control_q     <= '0;
            in1_q         <= '0;
            in2_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_cnt_q     <= '0;
            err_valid_q   <= 1'b0;
            err_control_q <= '0;
            err_in1_q     <= '0;
            err_in2_q     <= '0;
            err_exp_q     <= '0;
            err_act_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_HOLD;
                        settle_q      <= SW'(SETTLE-1);
                        control_q     <= '0;
                        in1_q         <= '0;
                        in2_q         <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        err_cnt_q     <= '0;
                        err_valid_q   <= 1'b0;
                        err_control_q <= '0;
                        err_in1_q     <= '0;
                        err_in2_q     <= '0;
                        err_exp_q     <= '0;
                        err_act_q     <= '0;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (settle_q == '0) begin
                        state_q <= S_CHECK;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        // Abort wins: this edge's compare is dropped.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            if (!(&err_cnt_q)) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                            if (!err_valid_q) begin
                                err_valid_q   <= 1'b1;
                                err_control_q <= control_q;
                                err_in1_q     <= in1_q;
                                err_in2_q     <= in2_q;
                                err_exp_q     <= out_data_ref;
                                err_act_q     <= out_data_dut;
                            end
                        end
                        if (last_vec) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_HOLD;
                            settle_q  <= SW'(SETTLE-1);
                            control_q <= control_d;
                            in1_q     <= in1_d;
                            in2_q     <= in2_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign control     = control_q;
    assign in_data1    = in1_q;
    assign in_data2    = in2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = done_q && (err_cnt_q == '0);
    assign error_count = err_cnt_q;
    assign err_valid   = err_valid_q;
    assign err_control = err_control_q;
    assign err_in1     = err_in1_q;
    assign err_in2     = err_in2_q;
    assign err_exp     = err_exp_q;
    assign err_act     = err_act_q;

endmodule

// File: tb/tb_alu_bist_sweep.sv
module tb_alu_bist_sweep;

    localparam int WIDTH   = 4;
    localparam int NUM_OPS = 5;
    localparam int NV      = NUM_OPS * 256;
    localparam int SWEEP   = NV * 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       all_bad = 1'b0;
    logic [7:0] fmask [NV];

    logic [2:0]  control, err_control;
    logic [3:0]  in_data1, in_data2, err_in1, err_in2;
    logic [7:0]  out_data_dut, out_data_ref, err_exp, err_act;
    logic        busy, done, pass, err_valid;
    logic [10:0] error_count;

    // Second instance with an 8-bit counter whose DUT side never matches.
    logic [2:0]  s_control, s_err_control;
    logic [3:0]  s_in1, s_in2, s_err_in1, s_err_in2;
    logic [7:0]  s_ref, s_dut, s_err_exp, s_err_act;
    logic        s_busy, s_done, s_pass, s_err_valid;
    logic [7:0]  s_count;

    int n_checks = 0;
    int n_errors = 0;
    int vidx;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b);
        case (c)
            3'd0:    return {4'd0, a} + {4'd0, b};
            3'd1:    return {4'd0, a} - {4'd0, b};
            3'd2:    return {4'd0, a} * {4'd0, b};
            3'd3:    return {4'd0, a & b};
            3'd4:    return {4'd0, a ^ b};
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        vidx         = int'(in_data1) * 16 * NUM_OPS + int'(in_data2) * NUM_OPS + int'(control);
        out_data_ref = alu_model(control, in_data1, in_data2);
        out_data_dut = out_data_ref;
        if (all_bad)
            out_data_dut = ~out_data_ref;
        else if (vidx < NV)
            out_data_dut = out_data_ref ^ fmask[vidx];
        s_ref = alu_model(s_control, s_in1, s_in2);
        s_dut = ~s_ref;
    end

    alu_bist_sweep #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .control(control), .in_data1(in_data1), .in_data2(in_data2),
        .out_data_dut(out_data_dut), .out_data_ref(out_data_ref),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .err_valid(err_valid), .err_control(err_control), .err_in1(err_in1),
        .err_in2(err_in2), .err_exp(err_exp), .err_act(err_act)
    );

    alu_bist_sweep #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SETTLE(1), .CNT_W(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .control(s_control), .in_data1(s_in1), .in_data2(s_in2),
        .out_data_dut(s_dut), .out_data_ref(s_ref),
        .busy(s_busy), .done(s_done), .pass(s_pass), .error_count(s_count),
        .err_valid(s_err_valid), .err_control(s_err_control), .err_in1(s_err_in1),
        .err_in2(s_err_in2), .err_exp(s_err_exp), .err_act(s_err_act)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < NV; i++) fmask[i] = 8'd0;
    endtask

    // Sweep started on edge N; returns edges from N until done (or abort exit).
    task automatic run_sweep(input int restart_at, input int abort_at, output int cycles);
        int n;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_cnt", 32'(error_count), 32'd0);
        check("start_errv", 32'(err_valid), 32'd0);
        n = 0;
        while (n < 6000) begin
            @(posedge clk);
            n++;
            #1;
            start = (n == restart_at);
            abort = (n == abort_at);
            if (done || (abort_at >= 0 && n == abort_at + 1)) break;
        end
        start = 1'b0;
        abort = 1'b0;
        if (n >= 6000) check("sweep_timeout", 32'd0, 32'd1);
        cycles = n;
    endtask

    // Compares result registers with the fault table (first fault = lowest sweep index).
    task automatic verify_results(input string tag, input int upto, input logic exp_done);
        int cnt, first;
        logic [2:0] fc;
        logic [3:0] fa, fb;
        logic [7:0] fe;
        cnt = 0;
        first = -1;
        for (int i = 0; i < upto; i++) begin
            if (fmask[i] != 8'd0) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check({tag, "_cnt"}, 32'(error_count), 32'(cnt));
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'(exp_done && cnt == 0));
        check({tag, "_errv"}, 32'(err_valid), 32'(first >= 0));
        if (first >= 0) begin
            fc = 3'(first % NUM_OPS);
            fb = 4'((first / NUM_OPS) % 16);
            fa = 4'(first / (NUM_OPS * 16));
            fe = alu_model(fc, fa, fb);
            check({tag, "_ectl"}, 32'(err_control), 32'(fc));
            check({tag, "_ein1"}, 32'(err_in1), 32'(fa));
            check({tag, "_ein2"}, 32'(err_in2), 32'(fb));
            check({tag, "_eexp"}, 32'(err_exp), 32'(fe));
            check({tag, "_eact"}, 32'(err_act), 32'(fe ^ fmask[first]));
        end
    endtask

    initial begin
        int cyc, k, idx;
        clear_faults();
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(error_count), 32'd0);
        check("rst_ctl", 32'({control, in_data1, in_data2}), 32'd0);
        check("rst_errv", 32'(err_valid), 32'd0);
        rst_n = 1'b1;

        // Matching ALUs.
        run_sweep(-1, -1, cyc);
        check("clean_len", 32'(cyc), 32'(SWEEP));
        verify_results("clean", NV, 1'b1);

        // Single fault at (3,5,9).
        fmask[5 * 16 * NUM_OPS + 9 * NUM_OPS + 3] = 8'h01;
        run_sweep(-1, -1, cyc);
        verify_results("single", NV, 1'b1);

        // Random fault sets; first one also gets a start pulse mid-sweep.
        for (int t = 0; t < 3; t++) begin
            clear_faults();
            k = $urandom_range(4, 1);
            for (int j = 0; j < k; j++) fmask[$urandom_range(NV - 1, 0)] = 8'($urandom_range(255, 1));
            run_sweep(t == 0 ? 100 : -1, -1, cyc);
            check("rand_len", 32'(cyc), 32'(SWEEP));
            verify_results("rand", NV, 1'b1);
        end

        // Every vector mismatches; the 8-bit instance saturates.
        clear_faults();
        all_bad = 1'b1;
        for (int i = 0; i < NV; i++) fmask[i] = 8'hff;
        run_sweep(-1, -1, cyc);
        verify_results("allbad", NV, 1'b1);
        check("sat_cnt", 32'(s_count), 32'd255);
        check("sat_done", 32'(s_done), 32'd1);
        check("sat_pass", 32'(s_pass), 32'd0);
        all_bad = 1'b0;

        // Abort at cycle 500 with one earlier fault.
        clear_faults();
        idx = $urandom_range(200, 0);
        fmask[idx] = 8'($urandom_range(255, 1));
        run_sweep(-1, 500, cyc);
        check("abort_len", 32'(cyc), 32'd501);
        verify_results("abort", NV, 1'b0);
        repeat (5) @(posedge clk);
        #1 check("abort_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-sweep.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cnt", 32'(error_count), 32'd0);
        check("arst_vec", 32'({control, in_data1, in_data2}), 32'd0);
        check("arst_err", 32'({err_valid, err_control, err_in1, err_in2}), 32'd0);
        check("arst_data", 32'({err_exp, err_act, 5'(0), done, pass}), 32'd0);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle", 32'({busy, done, control, in_data1, in_data2}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_bist_sweep.md
# alu_bist_sweep

Self-checking sweep engine that exercises two ALU implementations sharing the `control`/`in_data1`/`in_data2` interface and compares their `out_data` results. It walks every operand pair and opcode, counts mismatches, and captures the first failing vector. It sits beside the ALU pair in silicon or FPGA builds as the hardware counterpart of the software equivalence bench. Results are readable after `done` without a simulator.

## Interface
- `WIDTH`, 4: operand width of the ALUs under test.
- `NUM_OPS`, 5: opcodes swept, `control` = 0 .. NUM_OPS-1; legal range 1..8.
- `SETTLE`, 1: cycles a vector is held before compare; legal range ≥1.
- `CNT_W`, 2*WIDTH+3: width of the error counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- `abort`  in  1  stops a running sweep.
- `control`  out  3  opcode driven to both ALUs (registered).
- `in_data1`  out  WIDTH  operand A driven to both ALUs (registered).
- `in_data2`  out  WIDTH  operand B driven to both ALUs (registered).
- `out_data_dut`  in  2*WIDTH  result of the implementation under test.
- `out_data_ref`  in  2*WIDTH  result of the reference implementation.
- `busy`  out  1  high while sweeping.
- `done`  out  1  high after a completed sweep until next `start` or reset.
- `pass`  out  1  `done` AND `error_count == 0`.
- `error_count`  out  CNT_W  mismatch count, saturating.
- `err_valid`  out  1  first mismatch captured.
- `err_control`, `err_in1`, `err_in2`  out  3/WIDTH/WIDTH  first failing vector.
- `err_exp`, `err_act`  out  2*WIDTH  `out_data_ref` / `out_data_dut` at first failure.

## Operation
- States: IDLE, HOLD, CHECK, DONE.
- IDLE: `start` → clear `error_count`, `err_*`, `done`. Load vector (0,0,0) and go to HOLD.
- HOLD: hold the vector for SETTLE cycles, counting from the cycle the vector appears on the outputs. Then go to CHECK.
- CHECK: compare `out_data_dut` with `out_data_ref` on this clock edge.
  - On mismatch, increment `error_count`; it saturates at 2^CNT_W-1 and never wraps.
  - On the first mismatch, set `err_valid` and latch the `err_*` fields. Later mismatches do not overwrite them.
  - On the same edge, advance to the next vector and return to HOLD. After the last vector, go to DONE instead.
- Sweep order: `control` is the innermost loop (0..NUM_OPS-1), then `in_data2` (0..2^WIDTH-1), then `in_data1` as the outermost loop. The vector after (NUM_OPS-1, x, 2^WIDTH-1) is (0, x+1, 0). The last vector is (NUM_OPS-1, 2^WIDTH-1, 2^WIDTH-1).
- DONE: `busy`=0, `done`=1. Vector outputs keep the last vector. `start` begins a fresh sweep, with the same actions as from IDLE.
- `start` while in HOLD or CHECK is ignored.
- `abort` in HOLD or CHECK → IDLE on the next edge. `error_count` and `err_*` are kept, `done` stays 0. `abort` has priority over the CHECK compare: the compare on that edge is discarded.
- Reset (any state, asynchronous): state IDLE. `control`, `in_data1`, `in_data2`, `busy`, `done`, `pass`, `error_count`, `err_valid`, and all `err_*` go to 0.

## Timing
- `start` sampled on edge N → first vector visible and `busy`=1 after edge N.
- Each vector occupies SETTLE+1 cycles. Total sweep = NUM_OPS·2^(2·WIDTH)·(SETTLE+1) cycles. This is 2560 cycles for the defaults.
- `error_count` and `err_*` update on the CHECK edge of the failing vector.
- `done` rises on the CHECK edge of the last vector, together with the final count update. `busy` falls on the same edge.
- ALU outputs must be stable SETTLE cycles after the vector changes; combinational ALUs meet this with SETTLE=1.

## Test plan
- Identical behavioural ALUs on both inputs, defaults: `start` → `done`=1 exactly 2560 cycles later, `error_count`=0, `pass`=1, `err_valid`=0.
- Reference is correct; DUT result is XORed with 1 only at (control=3, in1=5, in2=9): `error_count`=1, `err_valid`=1, `err_control`=3, `err_in1`=5, `err_in2`=9, `err_act`=`err_exp`^1, `pass`=0.
- DUT output tied to a constant that never matches: `error_count`=1280, first error captured at (0,0,0). Repeat with CNT_W=8: `error_count` saturates at 255.
- Pulse `start` again at cycle 100 of a sweep: no restart, total length still 2560 cycles. `start` after `done`: count and `err_*` cleared, new sweep runs.
- Drop `rst_n` mid-sweep, between clock edges: all outputs 0 immediately. After release, the block stays IDLE until `start`.
- `abort` at cycle 500 with one prior injected error: state IDLE next edge, `busy`=0, `done`=0, `error_count`=1, `err_*` unchanged.
